demux4_stream: RTL and testbench



---
 rtl/demux4_stream_pkg.sv | 14 +
 rtl/demux_lane_fifo.sv | 49 ++++
 rtl/demux4_stream.sv | 42 ++++
 tb/tb_demux4_stream.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/demux4_stream_pkg.sv
// Shared constants and lane enumeration for the 1:4 stream demux
// and its mirror-image 4:1 result mux.
package demux4_stream_pkg;
    localparam int LANES      = 4;
    localparam int SEL_W      = 2;
    localparam int LANE_DEPTH = 2;

    typedef enum logic [SEL_W-1:0] {
        LANE0 = 2'd0,
        LANE1 = 2'd1,
        LANE2 = 2'd2,
        LANE3 = 2'd3
    } lane_e;
endpackage

// File: rtl/demux_lane_fifo.sv
// Two-entry lane buffer with registered storage; the head word is read
// straight from a register so the output never sees input logic.
module demux_lane_fifo
    import demux4_stream_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [SIZE-1:0] push_data,
    input  logic            pop,
    output logic            full,
    output logic            valid,
    output logic [SIZE-1:0] head_data
);
    logic [SIZE-1:0] mem [LANE_DEPTH];
    logic            wptr, rptr;
    logic [1:0]      count;
    logic            do_push, do_pop;

    // Guard locally so a misbehaving parent can't overrun or underrun.
    assign do_push = push & ~full;
    assign do_pop  = pop & valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LANE_DEPTH; i++) mem[i] <= '0;
            wptr  <= 1'b0;
            rptr  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wptr] <= push_data;
                wptr      <= ~wptr;
            end
            if (do_pop) rptr <= ~rptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign full      = (count == 2'd2);
    assign valid     = (count != 2'd0);
    assign head_data = mem[rptr];
endmodule

// File: rtl/demux4_stream.sv
// 1:4 stream demux: decodes in_sel to one of four independent lane FIFOs.
// in_ready comes only from registered full flags, never from out_ready.
module demux4_stream
    import demux4_stream_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SIZE-1:0]       in_data,
    input  logic [SEL_W-1:0]      in_sel,
    output logic [LANES-1:0]      out_valid,
    input  logic [LANES-1:0]      out_ready,
    output logic [LANES*SIZE-1:0] out_data,
    output logic                  busy
);
    logic [LANES-1:0] full;
    logic [LANES-1:0] push;
    lane_e            sel;

    assign sel      = lane_e'(in_sel);
    assign in_ready = ~full[sel];

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign push[k] = in_valid & in_ready & (sel == lane_e'(k));

        demux_lane_fifo #(.SIZE(SIZE)) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push[k]),
            .push_data (in_data),
            .pop       (out_ready[k]),
            .full      (full[k]),
            .valid     (out_valid[k]),
            .head_data (out_data[k*SIZE +: SIZE])
        );
    end

    assign busy = |out_valid;
endmodule

// File: tb/tb_demux4_stream.sv
// Scoreboard bench: driver predicts acceptance from per-lane queues of
// depth 2; monitor checks every lane head and pops on handshakes.
module tb_demux4_stream;
    localparam int SIZE = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [SIZE-1:0] in_data;
    logic [1:0]      in_sel;
    logic [3:0]      out_valid;
    logic [3:0]      out_ready;
    logic [4*SIZE-1:0] out_data;
    logic            busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [SIZE-1:0] exp_q [4][$];

    demux4_stream #(.SIZE(SIZE)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [SIZE-1:0] act, input logic [SIZE-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus: inputs change at negedge, acceptance is predicted
    // from the reference queues, and accepted words enter the model at the edge.
    task automatic drive(input logic v, input logic [1:0] s, input logic [SIZE-1:0] d, input logic [3:0] ordy);
        logic acc;
        @(negedge clk);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = ordy;
        #2;
        check($sformatf("in_ready sel%0d", s), {31'd0, in_ready}, {31'd0, exp_q[s].size() < 2});
        acc = v && (exp_q[s].size() < 2);
        @(posedge clk);
        if (acc) exp_q[s].push_back(d);
    endtask

    // Offer a word until the model says it is taken (bounded).
    task automatic offer(input logic [1:0] s, input logic [SIZE-1:0] d, input logic [3:0] ordy);
        int tries = 0;
        while (exp_q[s].size() >= 2 && tries < 20) begin
            drive(1'b1, s, d, ordy);
            tries++;
        end
        drive(1'b1, s, d, ordy);
    endtask

    task automatic idle(input int n, input logic [3:0] ordy);
        for (int i = 0; i < n; i++) drive(1'b0, 2'(i), '0, ordy);
    endtask

    // Monitor: sample mid-low-phase, after driver updates, before the next edge.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (!rst) begin
                logic any;
                any = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    logic ev;
                    ev  = exp_q[k].size() != 0;
                    any = any | ev;
                    check($sformatf("out_valid[%0d]", k), {31'd0, out_valid[k]}, {31'd0, ev});
                    if (ev) begin
                        check($sformatf("lane%0d data", k), out_data[k*SIZE +: SIZE], exp_q[k][0]);
                        if (out_ready[k]) void'(exp_q[k].pop_front());
                    end
                end
                check("busy", {31'd0, busy}, {31'd0, any});
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 0; in_sel = 0; in_data = 0; out_ready = 0;
        @(negedge clk); @(negedge clk);
        check("reset out_valid", {28'd0, out_valid}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        for (int k = 0; k < 4; k++) check("reset out_data", out_data[k*SIZE +: SIZE], '0);
        rst = 1'b0;

        // Single route to lane 3, held until consumed.
        drive(1'b1, 2'd3, 32'hDEADBEEF, 4'b0000);
        idle(3, 4'b0000);
        idle(2, 4'b1000);

        // Fill lane 1, stall the third word, then drain in order.
        drive(1'b1, 2'd1, 32'h1, 4'b0000);
        drive(1'b1, 2'd1, 32'h2, 4'b0000);
        drive(1'b1, 2'd1, 32'h3, 4'b0000);
        drive(1'b1, 2'd1, 32'h3, 4'b0000);
        offer(2'd1, 32'h3, 4'b0010);
        idle(4, 4'b0010);

        // Lane independence: lane 0 full and stalled, lane 2 still accepts.
        drive(1'b1, 2'd0, 32'h10, 4'b0000);
        drive(1'b1, 2'd0, 32'h11, 4'b0000);
        drive(1'b1, 2'd0, 32'h12, 4'b0000);
        drive(1'b1, 2'd2, 32'hAA, 4'b0000);
        drive(1'b1, 2'd0, 32'h12, 4'b0000);
        idle(3, 4'b1111);

        // Simultaneous push and pop on lane 1 with one word held.
        drive(1'b1, 2'd1, 32'h44, 4'b0000);
        drive(1'b1, 2'd1, 32'h55, 4'b0010);
        check("simul count", exp_q[1].size(), 32'd1);
        idle(2, 4'b0010);

        // Streaming: 16 words round-robin, all lanes ready.
        for (int i = 0; i < 16; i++) drive(1'b1, 2'(i % 4), 32'h100 + i, 4'b1111);
        idle(2, 4'b1111);

        // Mid-run reset with lane 2 holding two words.
        drive(1'b1, 2'd2, 32'h21, 4'b0000);
        drive(1'b1, 2'd2, 32'h22, 4'b0000);
        @(negedge clk);
        in_valid = 0;
        rst = 1'b1;
        #1;
        check("async rst out_valid", {28'd0, out_valid}, 32'd0);
        check("async rst busy", {31'd0, busy}, 32'd0);
        for (int k = 0; k < 4; k++) exp_q[k].delete();
        @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 4; s++) drive(1'b0, 2'(s), '0, 4'b0000);

        // Randomized traffic.
        for (int i = 0; i < 400; i++)
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, 4'($urandom));
        idle(6, 4'b1111);
        for (int k = 0; k < 4; k++) check($sformatf("drain lane%0d", k), exp_q[k].size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
